// File: rtl/mwc_pkg.sv
// Shared types for the data-memory write checker.
// State encoding and fail-code constants.
package mwc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mwc_if.sv
// Control, store-bus and result bundle for mem_write_checker.
// master drives the store bus and table; slave is the checker.
interface mwc_if
  import mwc_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_EXP = 8
);
  localparam int IW = idx_w(MAX_EXP);
  localparam int LW = $clog2(MAX_EXP + 1);

  logic              start;
  logic              exp_we;
  logic [IW-1:0]     exp_idx;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic [LW-1:0]     exp_len;

  logic              memwrite;
  logic [ADDR_W-1:0] dataadr;
  logic [DATA_W-1:0] writedata;

  logic              busy;
  logic              done;
  logic              pass;
  logic              fail;
  logic [1:0]        fail_code;
  logic [LW-1:0]     match_count;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;

  modport master (
    output start, exp_we, exp_idx,
    output exp_addr, exp_data, exp_len,
    output memwrite, dataadr, writedata,
    input  busy, done, pass, fail,
    input  fail_code, match_count,
    input  fail_addr, fail_data
  );

  modport slave (
    input  start, exp_we, exp_idx,
    input  exp_addr, exp_data, exp_len,
    input  memwrite, dataadr, writedata,
    output busy, done, pass, fail,
    output fail_code, match_count,
    output fail_addr, fail_data
  );

endinterface

// File: rtl/mem_write_checker_exp_table.sv
// Expected-store register file: one write port,
// one combinational read port, cleared on reset.
module mwc_exp_table #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_EXP = 8,
  parameter int IW      = 3,
  parameter int LW      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IW-1:0]     wr_idx,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LW-1:0]     rd_idx,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [ADDR_W-1:0] addr_q [MAX_EXP];
  logic [DATA_W-1:0] data_q [MAX_EXP];

  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_EXP; i++) begin
      if (reset) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end else if (we && wr_idx == IW'(i)) begin
        addr_q[i] <= wr_addr;
        data_q[i] <= wr_data;
      end
    end
  end

  // Out-of-range reads return zero; the FSM never uses them.
  always_comb begin
    rd_addr = '0;
    rd_data = '0;
    for (int i = 0; i < MAX_EXP; i++) begin
      if (rd_idx == LW'(i)) begin
        rd_addr = addr_q[i];
        rd_data = data_q[i];
      end
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// In-order store checker for the core's data-memory write port
// with ignore window, cycle timeout and failure capture.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_EXP = 8,
  parameter int TIMEOUT = 1000,
  parameter int IGN_LO  = 80,
  parameter int IGN_HI  = 80
) (
  input  logic clk,
  input  logic reset,
  mwc_if.slave bus
);

  localparam int IW = idx_w(MAX_EXP);
  localparam int LW = $clog2(MAX_EXP + 1);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] WLO = ADDR_W'(IGN_LO);
  localparam logic [ADDR_W-1:0] WHI = ADDR_W'(IGN_HI);
  localparam logic [LW-1:0] LMAX = LW'(MAX_EXP);
  localparam logic [CW-1:0] CLAST = CW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [LW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     len_q, len_d;
  logic [LW-1:0]     mc_q, mc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        fc_q, fc_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  logic [DATA_W-1:0] fd_q, fd_d;

  logic              tab_we;
  logic              idx_ok;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_data;
  logic [LW-1:0]     len_sat;
  logic              hit;
  logic              in_win;

  assign idx_ok = {1'b0, bus.exp_idx} < (IW+1)'(MAX_EXP);
  assign tab_we = bus.exp_we && idx_ok && state_q != RUN;

  mwc_exp_table #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_EXP (MAX_EXP),
    .IW      (IW),
    .LW      (LW)
  ) u_tab (
    .clk     (clk),
    .reset   (reset),
    .we      (tab_we),
    .wr_idx  (bus.exp_idx),
    .wr_addr (bus.exp_addr),
    .wr_data (bus.exp_data),
    .rd_idx  (idx_q),
    .rd_addr (t_addr),
    .rd_data (t_data)
  );

  assign len_sat = (bus.exp_len > LMAX) ? LMAX
                                        : bus.exp_len;

  assign hit = bus.dataadr == t_addr
            && bus.writedata == t_data;

  assign in_win = bus.dataadr >= WLO
               && bus.dataadr <= WHI;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    mc_d    = mc_q;
    cnt_d   = cnt_q;
    fc_d    = fc_q;
    fa_d    = fa_q;
    fd_d    = fd_q;
    unique case (state_q)
      IDLE, PASS, FAIL: begin
        if (bus.start) begin
          state_d = (len_sat == '0) ? PASS : RUN;
          len_d   = len_sat;
          idx_d   = '0;
          mc_d    = '0;
          cnt_d   = '0;
          fc_d    = FC_NONE;
          fa_d    = '0;
          fd_d    = '0;
        end
      end
      RUN: begin
        if (bus.memwrite && hit) begin
          idx_d = idx_q + 1'b1;
          mc_d  = mc_q + 1'b1;
        end
        if (bus.memwrite && hit
            && idx_q + 1'b1 == len_q) begin
          state_d = PASS;
        end else if (bus.memwrite && !hit && !in_win) begin
          state_d = FAIL;
          fc_d    = FC_MISMATCH;
          fa_d    = bus.dataadr;
          fd_d    = bus.writedata;
        end else if (cnt_q == CLAST) begin
          state_d = FAIL;
          fc_d    = FC_TIMEOUT;
          fa_d    = '0;
          fd_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      mc_q    <= '0;
      cnt_q   <= '0;
      fc_q    <= FC_NONE;
      fa_q    <= '0;
      fd_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      mc_q    <= mc_d;
      cnt_q   <= cnt_d;
      fc_q    <= fc_d;
      fa_q    <= fa_d;
      fd_q    <= fd_d;
    end
  end

  // Flags decode straight from the state flop.
  assign bus.busy        = state_q == RUN;
  assign bus.pass        = state_q == PASS;
  assign bus.fail        = state_q == FAIL;
  assign bus.done        = bus.pass | bus.fail;
  assign bus.fail_code   = fc_q;
  assign bus.match_count = mc_q;
  assign bus.fail_addr   = fa_q;
  assign bus.fail_data   = fd_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed plus random bench for mem_write_checker against
// a queue-free behavioural model of the expected-store rules.
module tb_mem_write_checker;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int ME  = 8;
  localparam int TO  = 20;
  localparam int ILO = 80;
  localparam int IHI = 80;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mwc_if #(.ADDR_W(AW), .DATA_W(DW), .MAX_EXP(ME)) bus ();

  mem_write_checker #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .MAX_EXP (ME),
    .TIMEOUT (TO),
    .IGN_LO  (ILO),
    .IGN_HI  (IHI)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] ta [ME];
  logic [31:0] td [ME];
  int          mlen, mcnt, mcyc, mcode;
  bit          mrun, mpass, mfail;
  logic [31:0] mfa, mfd;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mrun = 0; mpass = 0; mfail = 0;
    mlen = 0; mcnt = 0; mcyc = 0; mcode = 0;
    mfa = 0; mfd = 0;
    for (int i = 0; i < ME; i++) begin
      ta[i] = 0;
      td[i] = 0;
    end
  endtask

  task automatic model_step();
    bit term;
    int a;
    if (rst) begin
      model_clear();
      return;
    end
    if (!mrun) begin
      if (bus.exp_we && int'(bus.exp_idx) < ME) begin
        ta[bus.exp_idx] = bus.exp_addr;
        td[bus.exp_idx] = bus.exp_data;
      end
      if (bus.start) begin
        mlen  = (int'(bus.exp_len) > ME) ? ME : int'(bus.exp_len);
        mcnt  = 0; mcyc = 0; mcode = 0;
        mfa   = 0; mfd = 0;
        mfail = 0;
        mpass = (mlen == 0);
        mrun  = (mlen != 0);
      end
      return;
    end
    term = 0;
    a = int'(bus.dataadr);
    if (bus.memwrite) begin
      if (bus.dataadr === ta[mcnt] && bus.writedata === td[mcnt]) begin
        mcnt++;
        if (mcnt == mlen) begin
          mrun = 0; mpass = 1; term = 1;
        end
      end else if (!(a >= ILO && a <= IHI)) begin
        mrun = 0; mfail = 1; mcode = 1; term = 1;
        mfa = bus.dataadr;
        mfd = bus.writedata;
      end
    end
    if (!term) begin
      mcyc++;
      if (mcyc == TO) begin
        mrun = 0; mfail = 1; mcode = 2;
        mfa = 0; mfd = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("busy",  bus.busy, mrun);
    chk("done",  bus.done, mpass | mfail);
    chk("pass",  bus.pass, mpass);
    chk("fail",  bus.fail, mfail);
    chk("code",  bus.fail_code, mcode);
    chk("count", bus.match_count, mcnt);
    chk("faddr", bus.fail_addr, mfa);
    chk("fdata", bus.fail_data, mfd);
    bus.start = 0;
    bus.exp_we = 0;
    bus.memwrite = 0;
    rst = 0;
  endtask

  task automatic wr(input int i, input int a, input int d);
    bus.exp_we = 1;
    bus.exp_idx = 3'(i);
    bus.exp_addr = a;
    bus.exp_data = d;
    tick();
  endtask

  task automatic go(input int n);
    bus.start = 1;
    bus.exp_len = 4'(n);
    tick();
  endtask

  task automatic st(input int a, input int d);
    bus.memwrite = 1;
    bus.dataadr = a;
    bus.writedata = d;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int r;
    bus.start = 0; bus.exp_we = 0; bus.exp_idx = 0;
    bus.exp_addr = 0; bus.exp_data = 0; bus.exp_len = 0;
    bus.memwrite = 0; bus.dataadr = 0; bus.writedata = 0;
    model_clear();

    rst = 1;
    tick();
    chk("rst_done", bus.done, 1'b0);

    // ignored store then match
    wr(0, 84, 7);
    go(1);
    st(80, 5);
    chk("t1_busy", bus.busy, 1'b1);
    st(84, 7);
    chk("t1_pass", bus.pass, 1'b1);
    chk("t1_cnt", bus.match_count, 4'd1);

    // data mismatch
    go(1);
    st(84, 6);
    chk("t2_code", bus.fail_code, 2'd1);
    chk("t2_addr", bus.fail_addr, 32'd84);
    chk("t2_data", bus.fail_data, 32'd6);

    // out of order, then in order
    wr(1, 88, 9);
    go(2);
    st(88, 9);
    chk("t3_addr", bus.fail_addr, 32'd88);
    chk("t3_cnt", bus.match_count, 4'd0);
    go(2);
    st(84, 7);
    st(88, 9);
    chk("t3_pass", bus.pass, 1'b1);
    chk("t3_cnt2", bus.match_count, 4'd2);

    // timeout exactly TO cycles after busy rises
    go(1);
    idle(TO - 1);
    chk("t4_busy", bus.busy, 1'b1);
    idle(1);
    chk("t4_code", bus.fail_code, 2'd2);
    chk("t4_addr", bus.fail_addr, 32'd0);
    go(1);
    idle(TO - 1);
    st(84, 7);
    chk("t4_lastpass", bus.pass, 1'b1);

    // len 0, and table write during RUN
    go(0);
    chk("t5_pass", bus.pass, 1'b1);
    chk("t5_busy", bus.busy, 1'b0);
    go(1);
    wr(0, 1, 2);
    st(84, 7);
    chk("t5_keep", bus.pass, 1'b1);

    // reset mid-run clears the table
    go(2);
    st(84, 7);
    rst = 1;
    tick();
    chk("t6_state", bus.busy, 1'b0);
    chk("t6_cnt", bus.match_count, 4'd0);
    go(1);
    st(0, 0);
    chk("t6_pass", bus.pass, 1'b1);

    // saturated length
    for (int i = 0; i < ME; i++) wr(i, 4 * (i + 30), i + 1);
    go(15);
    for (int i = 0; i < ME; i++) st(4 * (i + 30), i + 1);
    chk("sat_cnt", bus.match_count, 4'd8);
    chk("sat_pass", bus.pass, 1'b1);

    // random traffic checked against the model
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      if (!mrun) begin
        if (r < 30) begin
          wr(int'($urandom_range(0, ME - 1)),
             int'($urandom_range(0, 40)) * 4,
             int'($urandom_range(0, 15)));
        end else if (r < 55) begin
          go(int'($urandom_range(0, 12)));
        end else if (r < 58) begin
          rst = 1;
          tick();
        end else begin
          st(int'($urandom_range(0, 40)) * 4,
             int'($urandom_range(0, 15)));
        end
      end else begin
        if (r < 45) begin
          st(int'(ta[mcnt]), int'(td[mcnt]));
        end else if (r < 60) begin
          st(ILO, int'($urandom));
        end else if (r < 64) begin
          st(int'($urandom_range(0, 40)) * 4,
             int'($urandom_range(0, 15)));
        end else if (r < 70) begin
          wr(int'($urandom_range(0, ME - 1)), 4, 4);
        end else if (r < 74) begin
          go(1);
        end else if (r < 76) begin
          rst = 1;
          tick();
        end else begin
          tick();
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
